seven_seg_display_arbiter: RTL and testbench

Shares the single 8-digit seven-segment display among 4 requesters (e.g. game FSM, score keeper, timer, debug). Round-robin arbitration with a minimum on-screen hold time and a blank gap between owners. Drives the 32-bit nibble word into the seven-segment decoder. Generates the scan-rate tick that paces digit multiplexing.

---
 rtl/seven_seg_display_arbiter.sv | 177 +++++++++++++++++
 tb/tb_seven_seg_display_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin owner of the shared 8-digit display, with minimum hold, blank gap and scan tick.
// Optional urgent preemption by requester 0 when SEVEN_SEG_ARB_PREEMPT_EN is defined.
module seven_seg_display_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int SCAN_DIV    = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [3:0]   grant,
  output logic [31:0]  disp_data,
  output logic [1:0]   disp_owner,
  output logic         disp_valid,
  output logic         scan_tick
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    grant_q, grant_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          tick_q, tick_d;

  logic [31:0]   req_word [4];
  logic          arb_vld;
  logic [1:0]    arb_sel, arb_idx;
  logic          take_vld;
  logic [1:0]    take_sel;
  logic          others_pending;

  for (genvar g = 0; g < 4; g++) begin : g_word
    assign req_word[g] = req_data[32*g +: 32];
  end

  // Search starts just after the last owner, so the last owner is considered last.
  always_comb begin
    arb_vld = 1'b0;
    arb_sel = last_q;
    arb_idx = last_q;
    for (int i = 1; i <= 4; i++) begin
      arb_idx = last_q + 2'(i);
      if (!arb_vld && req[arb_idx]) begin
        arb_vld = 1'b1;
        arb_sel = arb_idx;
      end
    end
  end

  assign others_pending = |(req & ~(4'b0001 << owner_q));

  always_comb begin
    tick_d = (scan_q == SW'(SCAN_DIV - 1));
    scan_d = tick_d ? '0 : scan_q + 1'b1;
  end

`ifdef SEVEN_SEG_ARB_PREEMPT_EN
  logic req0_q;
  logic preempt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req0_q <= 1'b0;
    else        req0_q <= req[0];
  end

  assign preempt = (state_q == SHOW || state_q == GAP) && (owner_q != 2'd0) && req[0] && !req0_q;
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    last_d   = last_q;
    owner_d  = owner_q;
    grant_d  = 4'b0000;
    data_d   = data_q;
    valid_d  = valid_q;
    take_vld = 1'b0;
    take_sel = arb_sel;

    case (state_q)
      IDLE: begin
        data_d  = BLANK;
        valid_d = 1'b0;
        take_vld = arb_vld;
      end
      SHOW: begin
        hold_d = hold_q + 1'b1;
        if (req[owner_q]) data_d = req_word[owner_q];
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          if (others_pending) begin
            state_d = GAP;
            valid_d = 1'b0;
            data_d  = BLANK;
            gap_d   = '0;
          end else if (req[owner_q]) begin
            hold_d = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = BLANK;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (arb_vld) take_vld = 1'b1;
          else         state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SEVEN_SEG_ARB_PREEMPT_EN
    if (preempt) begin
      take_vld = 1'b1;
      take_sel = 2'd0;
    end
`endif

    if (take_vld) begin
      state_d = SHOW;
      grant_d = 4'b0001 << take_sel;
      owner_d = take_sel;
      data_d  = req_word[take_sel];
      valid_d = 1'b1;
      last_d  = take_sel;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      scan_q  <= '0;
      last_q  <= 2'd3;
      owner_q <= 2'd0;
      grant_q <= 4'b0000;
      data_q  <= BLANK;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      scan_q  <= scan_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
    end
  end

  assign grant      = grant_q;
  assign disp_data  = data_q;
  assign disp_owner = owner_q;
  assign disp_valid = valid_q;
  assign scan_tick  = tick_q;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed bench for seven_seg_display_arbiter with HOLD=8, GAP=2, SCAN_DIV=4.
module tb_seven_seg_display_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [127:0] req_data = '0;
  logic [3:0]   grant;
  logic [31:0]  disp_data;
  logic [1:0]   disp_owner;
  logic         disp_valid;
  logic         scan_tick;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_display_arbiter #(
    .HOLD_CYCLES(8),
    .GAP_CYCLES (2),
    .SCAN_DIV   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .disp_data (disp_data),
    .disp_owner(disp_owner),
    .disp_valid(disp_valid),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  // Leaves the bench just after a falling edge with reset released; the next rising edge is cycle 1.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b0000;
    #12;
    n_cmp++; if (disp_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL reset_data: got %h want ffffffff", disp_data); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", disp_valid); end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (disp_owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", disp_owner); end
    n_cmp++; if (scan_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", scan_tick); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++; if (scan_tick !== (k % 4 == 0)) begin n_err++; $display("FAIL scan_tick_c%0d: got %b want %b", k, scan_tick, (k % 4 == 0)); end
      n_cmp++; if (disp_valid !== 1'b0 || grant !== 4'b0000 || disp_data !== 32'hFFFFFFFF) begin
        n_err++; $display("FAIL idle_blank_c%0d: got v=%b g=%b d=%h want v=0 g=0000 d=ffffffff", k, disp_valid, grant, disp_data);
      end
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    req_data[63:32] = 32'h12345678;
    req = 4'b0010;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b want 0010", grant); end
    n_cmp++; if (disp_owner !== 2'd1) begin n_err++; $display("FAIL single_owner: got %0d want 1", disp_owner); end
    n_cmp++; if (disp_data !== 32'h12345678) begin n_err++; $display("FAIL single_data: got %h want 12345678", disp_data); end
    n_cmp++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", disp_valid); end
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_nogrant_c%0d: got %b want 0000", k, grant); end
      n_cmp++; if (disp_valid !== 1'b1 || disp_data !== 32'h12345678) begin
        n_err++; $display("FAIL single_hold_c%0d: got v=%b d=%h want v=1 d=12345678", k, disp_valid, disp_data);
      end
    end
    // Owner 1 still shown: data change must appear one cycle later.
    req_data[63:32] = 32'hFFFFFFA0;
    @(negedge clk);
    n_cmp++; if (disp_data !== 32'hFFFFFFA0) begin n_err++; $display("FAIL data_follow: got %h want ffffffa0", disp_data); end
    n_cmp++; if (disp_owner !== 2'd1) begin n_err++; $display("FAIL data_follow_owner: got %0d want 1", disp_owner); end
  endtask

  task automatic test_round_robin();
    logic [31:0] w [4];
    logic [3:0]  e_grant;
    logic        e_valid;
    logic [31:0] e_data;
    int          ph;
    int          own;
    for (int i = 0; i < 4; i++) w[i] = 32'hA0B0C0D0 + i;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[32*i +: 32] = w[i];
    req = 4'b1111;
    // Each slot: 8 shown cycles then 2 blank cycles; owners 0,1,2,3,0.
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      ph      = (k - 1) % 10;
      own     = ((k - 1) / 10) % 4;
      e_grant = (ph == 0) ? (4'b0001 << own) : 4'b0000;
      e_valid = (ph < 8);
      e_data  = e_valid ? w[own] : 32'hFFFFFFFF;
      n_cmp++; if (grant !== e_grant) begin n_err++; $display("FAIL rr_grant_c%0d: got %b want %b", k, grant, e_grant); end
      n_cmp++; if (disp_valid !== e_valid) begin n_err++; $display("FAIL rr_valid_c%0d: got %b want %b", k, disp_valid, e_valid); end
      n_cmp++; if (disp_data !== e_data) begin n_err++; $display("FAIL rr_data_c%0d: got %h want %h", k, disp_data, e_data); end
      if (e_valid) begin
        n_cmp++; if (disp_owner !== 2'(own)) begin n_err++; $display("FAIL rr_owner_c%0d: got %0d want %0d", k, disp_owner, own); end
      end
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req_data[95:64] = 32'h0000C0DE;
    req = 4'b0100;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    n_cmp++; if (disp_owner !== 2'd2 || disp_valid !== 1'b1) begin
      n_err++; $display("FAIL drop_owner: got o=%0d v=%b want o=2 v=1", disp_owner, disp_valid);
    end
    req = 4'b0000;
    req_data[95:64] = 32'h11111111;
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++; if (disp_data !== 32'h0000C0DE || disp_valid !== 1'b1) begin
        n_err++; $display("FAIL drop_freeze_c%0d: got v=%b d=%h want v=1 d=0000c0de", k, disp_valid, disp_data);
      end
    end
    for (int k = 9; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++; if (disp_data !== 32'hFFFFFFFF || disp_valid !== 1'b0 || grant !== 4'b0000) begin
        n_err++; $display("FAIL drop_idle_c%0d: got v=%b g=%b d=%h want v=0 g=0000 d=ffffffff", k, disp_valid, grant, disp_data);
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req_data[31:0]   = 32'h00000000;
    req_data[127:96] = 32'h33333333;
    req = 4'b1000;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    n_cmp++; if (disp_owner !== 2'd3) begin n_err++; $display("FAIL pre_owner3: got %0d want 3", disp_owner); end
    req = 4'b1001;
`ifdef SEVEN_SEG_ARB_PREEMPT_EN
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL pre_grant: got %b want 0001", grant); end
    n_cmp++; if (disp_owner !== 2'd0 || disp_valid !== 1'b1 || disp_data !== 32'h00000000) begin
      n_err++; $display("FAIL pre_show0: got o=%0d v=%b d=%h want o=0 v=1 d=00000000", disp_owner, disp_valid, disp_data);
    end
`else
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++; if (disp_owner !== 2'd3 || disp_valid !== 1'b1 || grant !== 4'b0000) begin
        n_err++; $display("FAIL nopre_hold_c%0d: got o=%0d v=%b g=%b want o=3 v=1 g=0000", k, disp_owner, disp_valid, grant);
      end
    end
    for (int k = 9; k <= 10; k++) begin
      @(negedge clk);
      n_cmp++; if (disp_valid !== 1'b0 || disp_data !== 32'hFFFFFFFF) begin
        n_err++; $display("FAIL nopre_gap_c%0d: got v=%b d=%h want v=0 d=ffffffff", k, disp_valid, disp_data);
      end
    end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001 || disp_owner !== 2'd0) begin
      n_err++; $display("FAIL nopre_grant0: got g=%b o=%0d want g=0001 o=0", grant, disp_owner);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[63:32] = 32'h87654321;
    req = 4'b0010;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    n_cmp++; if (disp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", disp_valid); end
    req = 4'b0110;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (disp_valid !== 1'b0 || disp_data !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL mid_reset_disp: got v=%b d=%h want v=0 d=ffffffff", disp_valid, disp_data);
    end
    n_cmp++; if (grant !== 4'b0000 || disp_owner !== 2'd0 || scan_tick !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_ctl: got g=%b o=%0d t=%b want g=0000 o=0 t=0", grant, disp_owner, scan_tick);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0010 || disp_owner !== 2'd1) begin
      n_err++; $display("FAIL mid_rearb: got g=%b o=%0d want g=0010 o=1", grant, disp_owner);
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_round_robin();
    test_owner_drop();
    test_preempt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
